// File: rtl/ball_motion.sv
// Ball physics stage: frame divider, erase/update/draw sequencer with wall bounce.
// Optional FRICTION_EN: every FRICTION_DIV-th update decays velocity toward zero.
module ball_motion #(
    parameter int unsigned SCREEN_W     = 160,
    parameter int unsigned SCREEN_H     = 120,
    parameter int unsigned BALL_SIZE    = 4,
    parameter int unsigned FRAME_DIV    = 833333,
    parameter int unsigned X_INIT       = 78,
    parameter int unsigned Y_INIT       = 58,
    parameter int unsigned FRICTION_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kick,
    input  logic [3:0] kick_vx,
    input  logic [3:0] kick_vy,
    input  logic       plot_ready,
    output logic       plot_valid,
    output logic       plot_erase,
    output logic [7:0] plot_x,
    output logic [6:0] plot_y,
    output logic [7:0] pos_x,
    output logic [6:0] pos_y,
    output logic [3:0] vel_x,
    output logic [3:0] vel_y,
    output logic       frame_tick,
    output logic       overrun
);

    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned V_W   = 4;
    localparam int unsigned N_W   = 10;
    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned MAX_X = SCREEN_W - BALL_SIZE;
    localparam int unsigned MAX_Y = SCREEN_H - BALL_SIZE;

    typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;

    typedef struct packed {
        logic [X_W-1:0] pos;
        logic [V_W-1:0] vel;
    } axis_t;

    // -(-8) does not fit in 4 bits; clamp to +7
    function automatic logic signed [V_W-1:0] neg_sat(input logic signed [V_W-1:0] v);
        if (v == 4'sb1000) return 4'sd7;
        return -v;
    endfunction

    function automatic axis_t axis_step(input logic [X_W-1:0] pos,
                                        input logic signed [V_W-1:0] vel,
                                        input logic [X_W-1:0] max_pos);
        logic signed [N_W-1:0] n;
        axis_t r;
        n     = $signed({2'b00, pos}) + N_W'(vel);
        r.pos = X_W'(n);
        r.vel = vel;
        if (n < 0) begin
            r.pos = '0;
            r.vel = neg_sat(vel);
        end else if (n > $signed({2'b00, max_pos})) begin
            r.pos = max_pos;
            r.vel = neg_sat(vel);
        end
        return r;
    endfunction

`ifdef FRICTION_EN
    localparam int unsigned FR_W = (FRICTION_DIV > 1) ? $clog2(FRICTION_DIV) : 1;

    function automatic logic [V_W-1:0] toward_zero(input logic signed [V_W-1:0] v);
        if (v > 0) return v - 4'sd1;
        if (v < 0) return v + 4'sd1;
        return v;
    endfunction

    logic [FR_W-1:0] fric_cnt_q, fric_cnt_d;
`endif

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  tick_q, tick_d;
    logic                  overrun_q, overrun_d;
    logic [X_W-1:0]        pos_x_q, pos_x_d;
    logic [Y_W-1:0]        pos_y_q, pos_y_d;
    logic signed [V_W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic                  pend_q, pend_d;
    logic [V_W-1:0]        pend_vx_q, pend_vx_d, pend_vy_q, pend_vy_d;
    logic                  plot_valid_q, plot_valid_d;
    logic                  plot_erase_q, plot_erase_d;
    logic [X_W-1:0]        plot_x_q, plot_x_d;
    logic [Y_W-1:0]        plot_y_q, plot_y_d;
    logic signed [V_W-1:0] vx_sel, vy_sel;
    axis_t                 ax, ay;

    // Next-state: divider, kick capture and the erase/update/draw sequence
    always_comb begin
        state_d      = state_q;
        overrun_d    = overrun_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        vel_x_d      = vel_x_q;
        vel_y_d      = vel_y_q;
        pend_d       = pend_q;
        pend_vx_d    = pend_vx_q;
        pend_vy_d    = pend_vy_q;
        plot_valid_d = plot_valid_q;
        plot_erase_d = plot_erase_q;
        plot_x_d     = plot_x_q;
        plot_y_d     = plot_y_q;
        vx_sel       = vel_x_q;
        vy_sel       = vel_y_q;
        ax           = '0;
        ay           = '0;
`ifdef FRICTION_EN
        fric_cnt_d   = fric_cnt_q;
`endif

        div_d  = (div_q == DIV_W'(FRAME_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_d == DIV_W'(FRAME_DIV - 1));

        if (tick_q && (state_q != IDLE)) overrun_d = 1'b1;

        if (kick) begin
            pend_d    = 1'b1;
            pend_vx_d = kick_vx;
            pend_vy_d = kick_vy;
        end

        case (state_q)
            IDLE: begin
                if (tick_q) begin
                    state_d      = ERASE;
                    plot_valid_d = 1'b1;
                    plot_erase_d = 1'b1;
                    plot_x_d     = pos_x_q;
                    plot_y_d     = pos_y_q;
                end
            end
            ERASE: begin
                if (plot_ready) begin
                    state_d      = UPDATE;
                    plot_valid_d = 1'b0;
                end
            end
            UPDATE: begin
                // A kick arriving this very cycle wins over the pending one
                if (kick) begin
                    vx_sel = $signed(kick_vx);
                    vy_sel = $signed(kick_vy);
                end else if (pend_q) begin
                    vx_sel = $signed(pend_vx_q);
                    vy_sel = $signed(pend_vy_q);
                end
                pend_d = 1'b0;
                ax = axis_step(pos_x_q, vx_sel, X_W'(MAX_X));
                ay = axis_step({1'b0, pos_y_q}, vy_sel, X_W'(MAX_Y));
`ifdef FRICTION_EN
                if (fric_cnt_q == FR_W'(FRICTION_DIV - 1)) begin
                    fric_cnt_d = '0;
                    ax.vel     = toward_zero($signed(ax.vel));
                    ay.vel     = toward_zero($signed(ay.vel));
                end else begin
                    fric_cnt_d = fric_cnt_q + FR_W'(1);
                end
`endif
                pos_x_d      = ax.pos;
                pos_y_d      = Y_W'(ay.pos);
                vel_x_d      = $signed(ax.vel);
                vel_y_d      = $signed(ay.vel);
                state_d      = DRAW;
                plot_valid_d = 1'b1;
                plot_erase_d = 1'b0;
                plot_x_d     = ax.pos;
                plot_y_d     = Y_W'(ay.pos);
            end
            DRAW: begin
                if (plot_ready) begin
                    state_d      = IDLE;
                    plot_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            tick_q       <= 1'b0;
            overrun_q    <= 1'b0;
            pos_x_q      <= X_W'(X_INIT);
            pos_y_q      <= Y_W'(Y_INIT);
            vel_x_q      <= '0;
            vel_y_q      <= '0;
            pend_q       <= 1'b0;
            pend_vx_q    <= '0;
            pend_vy_q    <= '0;
            plot_valid_q <= 1'b0;
            plot_erase_q <= 1'b0;
            plot_x_q     <= '0;
            plot_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            tick_q       <= tick_d;
            overrun_q    <= overrun_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            vel_x_q      <= vel_x_d;
            vel_y_q      <= vel_y_d;
            pend_q       <= pend_d;
            pend_vx_q    <= pend_vx_d;
            pend_vy_q    <= pend_vy_d;
            plot_valid_q <= plot_valid_d;
            plot_erase_q <= plot_erase_d;
            plot_x_q     <= plot_x_d;
            plot_y_q     <= plot_y_d;
        end
    end

`ifdef FRICTION_EN
    always_ff @(posedge clk) begin
        if (reset) fric_cnt_q <= '0;
        else       fric_cnt_q <= fric_cnt_d;
    end
`endif

    assign plot_valid = plot_valid_q;
    assign plot_erase = plot_erase_q;
    assign plot_x     = plot_x_q;
    assign plot_y     = plot_y_q;
    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign vel_x      = vel_x_q;
    assign vel_y      = vel_y_q;
    assign frame_tick = tick_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: plot requests predicted by a behavioural model into a queue.
module tb_ball_motion;

    localparam int MAXX = 160 - 4;
    localparam int MAXY = 120 - 4;
    localparam int FDIV = 2;

    logic       clk;
    logic       reset;
    logic       kick;
    logic [3:0] kick_vx;
    logic [3:0] kick_vy;
    logic       plot_ready;
    logic       plot_valid;
    logic       plot_erase;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic [3:0] vel_x;
    logic [3:0] vel_y;
    logic       frame_tick;
    logic       overrun;

    ball_motion #(
        .FRAME_DIV   (16),
        .FRICTION_DIV(FDIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .kick      (kick),
        .kick_vx   (kick_vx),
        .kick_vy   (kick_vy),
        .plot_ready(plot_ready),
        .plot_valid(plot_valid),
        .plot_erase(plot_erase),
        .plot_x    (plot_x),
        .plot_y    (plot_y),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .vel_x     (vel_x),
        .vel_y     (vel_y),
        .frame_tick(frame_tick),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_e;

    int m_x, m_y, m_vx, m_vy, m_pvx, m_pvy, m_upd;
    bit m_pend;

    // Every accepted request is compared with the oldest prediction
    always @(negedge clk) begin
        if (reset === 1'b0 && plot_valid === 1'b1 && plot_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL req_unexpected got erase=%b x=%0d y=%0d, want no request",
                         plot_erase, plot_x, plot_y);
            end else begin
                mon_e = exp_q.pop_front();
                if ({plot_erase, plot_x, plot_y} !== mon_e) begin
                    errors++;
                    $display("FAIL req got erase=%b x=%0d y=%0d, want erase=%b x=%0d y=%0d",
                             plot_erase, plot_x, plot_y, mon_e[15], mon_e[14:7], mon_e[6:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic void step(input int p, input int v, input int mx,
                                 output int np, output int nv);
        int n;
        n = p + v;
        if (n < 0) begin
            np = 0;
            nv = (v == -8) ? 7 : -v;
        end else if (n > mx) begin
            np = mx;
            nv = (v == -8) ? 7 : -v;
        end else begin
            np = n;
            nv = v;
        end
    endfunction

    task automatic model_reset();
        m_x = 78; m_y = 58; m_vx = 0; m_vy = 0;
        m_pend = 0; m_pvx = 0; m_pvy = 0; m_upd = 0;
    endtask

    task automatic model_update();
        int nx, ny, nvx, nvy;
        if (m_pend) begin
            m_vx = m_pvx;
            m_vy = m_pvy;
            m_pend = 0;
        end
        step(m_x, m_vx, MAXX, nx, nvx);
        step(m_y, m_vy, MAXY, ny, nvy);
        m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy;
`ifdef FRICTION_EN
        m_upd++;
        if (m_upd % FDIV == 0) begin
            m_vx = (m_vx > 0) ? m_vx - 1 : (m_vx < 0) ? m_vx + 1 : 0;
            m_vy = (m_vy > 0) ? m_vy - 1 : (m_vy < 0) ? m_vy + 1 : 0;
        end
`endif
    endtask

    task automatic do_kick(input int vx, input int vy);
        @(posedge clk);
        #1 kick = 1'b1; kick_vx = 4'(vx); kick_vy = 4'(vy);
        @(posedge clk);
        #1 kick = 1'b0;
        m_pend = 1; m_pvx = vx; m_pvy = vy;
    endtask

    task automatic wait_tick(output bit ok);
        int c;
        c = 0;
        @(negedge clk);
        while (frame_tick !== 1'b1 && c < 64) begin
            @(negedge clk);
            c++;
        end
        checks++;
        ok = (frame_tick === 1'b1);
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_timeout got frame_tick=%b after %0d cycles, want 1", frame_tick, c);
        end
    endtask

    // From a tick in IDLE: predict both requests, optionally stall the erase, wait for IDLE
    task automatic frame_body(input int stall);
        logic [15:0] er;
        int c;
        er = {1'b1, 8'(m_x), 7'(m_y)};
        exp_q.push_back(er);
        model_update();
        exp_q.push_back({1'b0, 8'(m_x), 7'(m_y)});
        if (stall > 0) begin
            plot_ready = 1'b0;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                checks++;
                if ({plot_valid, plot_erase, plot_x, plot_y} !== {1'b1, er}) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b e=%b x=%0d y=%0d, want v=1 e=1 x=%0d y=%0d",
                             plot_valid, plot_erase, plot_x, plot_y, er[14:7], er[6:0]);
                end
            end
            @(posedge clk);
            #1 plot_ready = 1'b1;
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(plot_valid === 1'b1 && plot_ready === 1'b1 && plot_erase === 1'b0) && c < 80);
        checks++;
        if ((plot_valid & plot_ready & ~plot_erase) !== 1'b1) begin
            errors++;
            $display("FAIL draw_timeout got valid=%b erase=%b, want draw request", plot_valid, plot_erase);
        end
        @(negedge clk);
        checks++;
        if ({plot_valid, pos_x, pos_y, vel_x, vel_y} !==
            {1'b0, 8'(m_x), 7'(m_y), 4'(m_vx), 4'(m_vy)}) begin
            errors++;
            $display("FAIL frame_end got v=%b pos=(%0d,%0d) vel=(%0d,%0d), want v=0 pos=(%0d,%0d) vel=(%0d,%0d)",
                     plot_valid, pos_x, pos_y, $signed(vel_x), $signed(vel_y), m_x, m_y, m_vx, m_vy);
        end
    endtask

    task automatic run_frame(input int stall);
        bit ok;
        wait_tick(ok);
        if (ok) frame_body(stall);
    endtask

    task automatic test_reset();
        reset = 1'b1; kick = 1'b0; kick_vx = '0; kick_vy = '0; plot_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({plot_valid, plot_erase, plot_x, plot_y, pos_x, pos_y, vel_x, vel_y, frame_tick, overrun} !==
            {1'b0, 1'b0, 8'd0, 7'd0, 8'd78, 7'd58, 4'd0, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got v=%b e=%b pxy=(%0d,%0d) pos=(%0d,%0d) vel=(%0d,%0d) tick=%b ovr=%b, want zeros and pos=(78,58)",
                     plot_valid, plot_erase, plot_x, plot_y, pos_x, pos_y, vel_x, vel_y, frame_tick, overrun);
        end
        reset = 1'b0;
    endtask

    task automatic test_first_frame();
        int c;
        c = 0;
        while (frame_tick !== 1'b1 && c < 64) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c !== 15) begin
            errors++;
            $display("FAIL first_tick got cycle %0d, want 15", c);
        end
        if (frame_tick === 1'b1) frame_body(0);
    endtask

    task automatic test_kick();
        do_kick(3, -2);
        run_frame(0);
`ifndef FRICTION_EN
        checks++;
        if ({pos_x, pos_y, vel_x, vel_y} !== {8'd81, 7'd56, 4'd3, 4'hE}) begin
            errors++;
            $display("FAIL kick_move got pos=(%0d,%0d) vel=(%0d,%0d), want pos=(81,56) vel=(3,-2)",
                     pos_x, pos_y, $signed(vel_x), $signed(vel_y));
        end
`endif
    endtask

    task automatic test_wall_x();
        do_kick(7, 0);
        repeat (10) run_frame(0);
        do_kick(4, 0);
        run_frame(0);
        do_kick(3, 0);
        run_frame(0);
`ifndef FRICTION_EN
        checks++;
        if ({pos_x, vel_x} !== {8'd156, 4'hD}) begin
            errors++;
            $display("FAIL wall_x_bounce got x=%0d vx=%0d, want x=156 vx=-3", pos_x, $signed(vel_x));
        end
`endif
        run_frame(0);
`ifndef FRICTION_EN
        checks++;
        if (pos_x !== 8'd153) begin
            errors++;
            $display("FAIL wall_x_after got x=%0d, want 153", pos_x);
        end
`endif
        do_kick(3, 0);
        run_frame(0);
`ifndef FRICTION_EN
        checks++;
        if ({pos_x, vel_x} !== {8'd156, 4'd3}) begin
            errors++;
            $display("FAIL wall_x_exact got x=%0d vx=%0d, want x=156 vx=3", pos_x, $signed(vel_x));
        end
`endif
    endtask

    task automatic test_wall_y();
        do_kick(0, -8);
        repeat (7) run_frame(0);
`ifndef FRICTION_EN
        checks++;
        if ({pos_y, vel_y} !== {7'd0, 4'h8}) begin
            errors++;
            $display("FAIL wall_y_exact got y=%0d vy=%0d, want y=0 vy=-8", pos_y, $signed(vel_y));
        end
`endif
        do_kick(0, 1);
        run_frame(0);
        do_kick(0, -8);
        run_frame(0);
`ifndef FRICTION_EN
        checks++;
        if ({pos_y, vel_y} !== {7'd0, 4'd7}) begin
            errors++;
            $display("FAIL wall_y_sat got y=%0d vy=%0d, want y=0 vy=7", pos_y, $signed(vel_y));
        end
`endif
    endtask

    task automatic test_stall();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_idle got %b, want 0", overrun);
        end
        run_frame(40);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set got %b, want 1", overrun);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_tick(ok);
        plot_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({plot_valid, plot_erase} !== 2'b11) begin
            errors++;
            $display("FAIL mid_erase got v=%b e=%b, want v=1 e=1", plot_valid, plot_erase);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({plot_valid, overrun, pos_x, pos_y} !== {1'b0, 1'b0, 8'd78, 7'd58}) begin
            errors++;
            $display("FAIL mid_reset got v=%b ovr=%b pos=(%0d,%0d), want v=0 ovr=0 pos=(78,58)",
                     plot_valid, overrun, pos_x, pos_y);
        end
        reset = 1'b0;
        plot_ready = 1'b1;
        model_reset();
        exp_q.delete();
    endtask

    task automatic test_friction();
        int fexp[4];
`ifdef FRICTION_EN
        fexp = '{3, 2, 2, 1};
`else
        fexp = '{3, 3, 3, 3};
`endif
        do_kick(7, 7);
        do_kick(3, 0);
        for (int i = 0; i < 4; i++) begin
            run_frame(0);
            checks++;
            if (vel_x !== 4'(fexp[i])) begin
                errors++;
                $display("FAIL friction_%0d got vx=%0d, want %0d", i + 1, $signed(vel_x), fexp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_kick();
        test_wall_x();
        test_wall_y();
        test_stall();
        test_reset_mid();
        test_friction();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending requests, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Physics stage directly upstream of the pixel plotter.
- Divides the system clock into frame ticks and holds the ball position and velocity.
- On each tick, issues an erase request for the old position, then computes a new position with wall bounce, then issues a draw request.
- Requests go to the plotter over a valid/ready handshake.

Parameters:
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- BALL_SIZE, 4, ball edge length in pixels; the position is the top-left corner.
- FRAME_DIV, 833333, clk cycles per frame tick (50 MHz / 60).
- X_INIT, 78, reset x position.
- Y_INIT, 58, reset y position.
- FRICTION_DIV, 8, frames between friction decrements (used only with FRICTION_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- kick  in  1  one-cycle pulse; load a new velocity.
- kick_vx  in  4  signed x velocity, sampled when kick=1.
- kick_vy  in  4  signed y velocity, sampled when kick=1.
- plot_ready  in  1  plotter accepts the current request.
- plot_valid  out  1  request present.
- plot_erase  out  1  1 = erase square at plot_x/plot_y; 0 = draw it.
- plot_x  out  8  request x (top-left).
- plot_y  out  7  request y (top-left).
- pos_x  out  8  current x position.
- pos_y  out  7  current y position.
- vel_x  out  4  signed current x velocity.
- vel_y  out  4  signed current y velocity.
- frame_tick  out  1  one-cycle pulse each frame.
- overrun  out  1  sticky; a tick arrived while not IDLE.

Behaviour:
- Reset (sync, active-high), all outputs:
  - pos_x=X_INIT, pos_y=Y_INIT; vel_x=vel_y=0.
  - state=IDLE; divider=0; frame_tick=0; overrun=0.
  - plot_valid=0, plot_erase=0, plot_x=0, plot_y=0.
  - Pending kick cleared.
- Divider:
  - Counts 0..FRAME_DIV-1 and wraps to 0.
  - frame_tick=1 for exactly the cycle where the count equals FRAME_DIV-1.
  - Free-running; not stalled by the FSM.
- FSM states: IDLE, ERASE, UPDATE, DRAW.
  - IDLE: on frame_tick go to ERASE; plot_valid=1, plot_erase=1, plot_x/plot_y = pos_x/pos_y from the next cycle.
  - ERASE: hold plot_valid and all plot_* stable until plot_valid&plot_ready. On that cycle go to UPDATE; plot_valid=0 next cycle.
  - UPDATE: exactly one cycle; position and velocity registers update; go to DRAW.
  - DRAW: plot_valid=1, plot_erase=0, plot_x/plot_y = new pos. Hold until plot_valid&plot_ready, then return to IDLE.
  - Minimum tick-to-IDLE time: 4 cycles when plot_ready is held high.
- Ticks outside IDLE:
  - frame_tick in ERASE/UPDATE/DRAW is dropped and sets overrun=1.
  - overrun clears only on reset.
- Kick:
  - kick=1 latches kick_vx/kick_vy into a pending register; a later kick overwrites it.
  - Pending is applied in UPDATE: the velocity loads from pending before the position step, and pending clears.
  - A kick in the same cycle as UPDATE is applied in that UPDATE.
- Position step, per axis, computed in 10-bit signed:
  - n = pos + vel. MAXX = SCREEN_W-BALL_SIZE; MAXY = SCREEN_H-BALL_SIZE.
  - n<0: pos=0, vel=-vel.
  - n>MAX: pos=MAX, vel=-vel.
  - Otherwise pos=n, vel unchanged.
  - n exactly 0 or exactly MAX is in range: no bounce.
  - Negating -8 saturates to +7.
- Reset mid-handshake: the request is dropped immediately and plot_valid=0 on the next cycle.

Optional Feature:
- Macro: FRICTION_EN.
- Defined:
  - A frame counter counts UPDATE cycles.
  - Every FRICTION_DIV-th UPDATE, after the bounce, each nonzero velocity component moves one step toward 0.
  - Friction is applied after any kick load in the same UPDATE.
- Undefined: velocity changes only by kick or bounce; no frame counter is synthesised.

Test Plan (FRAME_DIV=16 unless stated):
1. Reset, plot_ready=1 -> frame_tick at cycle 15.
   - Next cycle: ERASE request (78,58,erase=1).
   - After UPDATE: DRAW request (78,58,erase=0), since vel=0.
   - pos unchanged.
2. kick vx=+3, vy=-2, then tick -> DRAW at (81,56); vel_x=3, vel_y=-2.
3. pos_x=155, vx=+3 (MAXX=156) -> pos_x=156, vel_x=-3. Next frame: pos_x=153.
4. pos_y=1, vy=-8 -> pos_y=0, vel_y=+7 (saturated negate).
5. plot_ready=0 for 40 cycles during ERASE:
   - plot_* held stable; overrun=1 after the tick at cycle 31.
   - Release plot_ready -> one DRAW follows, then IDLE.
6. FRICTION_EN, FRICTION_DIV=2, kick vx=+3 -> vel_x after UPDATEs 1..4 is 3, 2, 2, 1.
   - Without FRICTION_EN: vel_x stays 3.
